// File: rtl/ins_seq_ctrl.sv
// ins_seq_ctrl: instruction-memory sequencer between program source and cpu.
// Buffers a streamed program, releases the core, serves ins_out = prog[pc].
//   load_valid/load_ready/load_data/load_last : program load port
//   start, abort                               : run control pulses
//   pc -> ins_out, cpu_set                     : cpu fetch side
//   prog_len, busy, done, timeout, cycle_cnt   : status
module ins_seq_ctrl #(
    parameter int                 INS_W      = 32,
    parameter int                 PC_W       = 8,
    parameter int                 DEPTH      = 256,
    parameter int                 MAX_CYCLES = 1000,
    parameter logic [INS_W-1:0]   NOP_INS    = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [INS_W-1:0] load_data,
    input  logic             load_last,
    input  logic             start,
    input  logic             abort,
    input  logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] ins_out,
    output logic             cpu_set,
    output logic [PC_W:0]    prog_len,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(DEPTH - 1);
    localparam logic [31:0]     CNT_LAST  = 32'(MAX_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  wr_ptr;
    logic [PC_W-1:0]  wr_addr;
    logic [INS_W-1:0] mem [DEPTH];
    logic             accept;
    logic             pc_end;
    logic             cnt_hit;
    logic             first_last;

    assign load_ready = (state == S_IDLE) || (state == S_LOAD) ||
                        (state == S_DONE);
    assign accept     = load_valid && load_ready && !abort;
    // pc is zero-extended so a full 2**PC_W program is representable
    assign pc_end     = {1'b0, pc} >= prog_len;
    // counter is about to reach the limit on this RUN edge
    assign cnt_hit    = cycle_cnt >= CNT_LAST;
    assign wr_addr    = (state == S_LOAD) ? wr_ptr : '0;
    assign first_last = load_last || (LAST_ADDR == '0);

    assign ins_out = (state == S_RUN && !pc_end) ? mem[pc] : NOP_INS;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept)
                        state_nxt = first_last ? S_READY : S_LOAD;
                end
                S_LOAD: begin
                    if (accept && (load_last || wr_ptr == LAST_ADDR))
                        state_nxt = S_READY;
                end
                S_READY: begin
                    if (start)
                        state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (pc_end || cnt_hit)
                        state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (accept)
                        state_nxt = first_last ? S_READY : S_LOAD;
                    else if (start)
                        state_nxt = S_RUN;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_set   <= 1'b0;
            wr_ptr    <= '0;
            prog_len  <= '0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt == S_LOAD) || (state_nxt == S_RUN);
            done    <= (state_nxt == S_DONE);
            cpu_set <= (state_nxt == S_RUN);
            if (abort) begin
                wr_ptr   <= '0;
                prog_len <= '0;
                timeout  <= 1'b0;
            end else if (accept) begin
                if (state == S_LOAD) begin
                    wr_ptr   <= wr_ptr + PC_W'(1);
                    prog_len <= prog_len + (PC_W+1)'(1);
                end else begin
                    wr_ptr   <= PC_W'(1);
                    prog_len <= (PC_W+1)'(1);
                    timeout  <= 1'b0;
                end
            end else if (start && (state == S_READY || state == S_DONE)) begin
                cycle_cnt <= '0;
                timeout   <= 1'b0;
            end else if (state == S_RUN) begin
                if (cycle_cnt != '1)
                    cycle_cnt <= cycle_cnt + 32'd1;
                // end of program takes precedence over the limit
                if (!pc_end && cnt_hit)
                    timeout <= 1'b1;
            end
        end
    end

    // program buffer is deliberately not reset
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_addr] <= load_data;
    end

endmodule

// File: tb/tb_ins_seq_ctrl.sv
// tb_ins_seq_ctrl: directed bench for ins_seq_ctrl with a behavioural model
// compared every cycle, plus literal expectations.
module tb_ins_seq_ctrl;

    localparam int          MAXC = 1000;
    localparam logic [31:0] NOP  = 32'h00000013;

    localparam int IDLE = 0;
    localparam int LOADING = 1;
    localparam int WAITING = 2;
    localparam int RUNNING = 3;
    localparam int FINISHED = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic        load_last;
    logic        start;
    logic        abort;
    logic [7:0]  pc;
    logic [31:0] ins_out;
    logic        cpu_set;
    logic [8:0]  prog_len;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_cnt;

    always #5 clk = ~clk;

    ins_seq_ctrl #(
        .INS_W(32),
        .PC_W(8),
        .DEPTH(256),
        .MAX_CYCLES(MAXC),
        .NOP_INS(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data(load_data),
        .load_last(load_last),
        .start(start),
        .abort(abort),
        .pc(pc),
        .ins_out(ins_out),
        .cpu_set(cpu_set),
        .prog_len(prog_len),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .cycle_cnt(cycle_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: program kept as an array plus a length.
    int          m_mode = IDLE;
    int          m_len  = 0;
    logic [31:0] m_cnt  = 0;
    logic        m_to   = 1'b0;
    logic [31:0] m_prog [256];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = IDLE;
            m_len  = 0;
            m_cnt  = 0;
            m_to   = 1'b0;
        end else begin : step_model
            bit open;
            open = (m_mode == IDLE) || (m_mode == LOADING) ||
                   (m_mode == FINISHED);
            if (abort) begin
                m_mode = IDLE;
                m_len  = 0;
                m_to   = 1'b0;
            end else if (open && load_valid) begin
                if (m_mode != LOADING) begin
                    m_len = 0;
                    m_to  = 1'b0;
                end
                m_prog[m_len] = load_data;
                m_len = m_len + 1;
                m_mode = (load_last || m_len == 256) ? WAITING : LOADING;
            end else if (start && (m_mode == WAITING || m_mode == FINISHED)) begin
                m_mode = RUNNING;
                m_cnt  = 0;
                m_to   = 1'b0;
            end else if (m_mode == RUNNING) begin
                if (m_cnt != 32'hFFFF_FFFF)
                    m_cnt = m_cnt + 1;
                if (int'(pc) >= m_len) begin
                    m_mode = FINISHED;
                end else if (m_cnt >= MAXC) begin
                    m_mode = FINISHED;
                    m_to   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin : cmp
            logic [31:0] e_ins;
            e_ins = (m_mode == RUNNING && int'(pc) < m_len) ? m_prog[pc] : NOP;
            chk("m_load_ready", 64'(load_ready),
                64'(m_mode == IDLE || m_mode == LOADING || m_mode == FINISHED));
            chk("m_cpu_set", 64'(cpu_set), 64'(m_mode == RUNNING));
            chk("m_busy", 64'(busy), 64'(m_mode == LOADING || m_mode == RUNNING));
            chk("m_done", 64'(done), 64'(m_mode == FINISHED));
            chk("m_prog_len", 64'(prog_len), 64'(m_len));
            chk("m_timeout", 64'(timeout), 64'(m_to));
            chk("m_cycle_cnt", 64'(cycle_cnt), 64'(m_cnt));
            chk("m_ins_out", 64'(ins_out), 64'(e_ins));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = l;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_seq(input string tag);
        for (int i = 0; i < 5; i++) begin
            pc = 8'(i);
            #1;
            chk(tag, 64'(ins_out), (i < 4) ? 64'(32'hA0 + i) : 64'(NOP));
            step();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pc         = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_ready", 64'(load_ready), 64'(1));
        chk("rst_cpu_set", 64'(cpu_set), 64'(0));
        chk("rst_ins_out", 64'(ins_out), 64'(NOP));
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rst_prog_len", 64'(prog_len), 64'(0));
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'(0));
        chk("rst_busy_done", 64'({busy, done, timeout}), 64'(0));

        // four-word program, normal end
        beat(32'hA0, 1'b0);
        chk("load_busy", 64'(busy), 64'(1));
        beat(32'hA1, 1'b0);
        beat(32'hA2, 1'b0);
        beat(32'hA3, 1'b1);
        chk("ready_len", 64'(prog_len), 64'(4));
        chk("ready_no_load", 64'(load_ready), 64'(0));
        pulse_start();
        chk("run_cpu_set", 64'(cpu_set), 64'(1));
        chk("run_cnt0", 64'(cycle_cnt), 64'(0));
        run_seq("ins_run1");
        chk("end_done", 64'(done), 64'(1));
        chk("end_cnt", 64'(cycle_cnt), 64'(5));
        chk("end_timeout", 64'(timeout), 64'(0));
        chk("end_cpu_set", 64'(cpu_set), 64'(0));

        // re-run from DONE
        pc = 8'd0;
        pulse_start();
        chk("rerun_cnt0", 64'(cycle_cnt), 64'(0));
        run_seq("ins_run2");
        chk("rerun_cnt", 64'(cycle_cnt), 64'(5));

        // beat and start together in DONE: the load wins
        load_valid = 1'b1;
        load_data  = 32'hB0;
        start      = 1'b1;
        step();
        load_valid = 1'b0;
        start      = 1'b0;
        chk("done_beat_len", 64'(prog_len), 64'(1));
        chk("done_beat_busy", 64'(busy), 64'(1));
        chk("done_beat_cpu", 64'(cpu_set), 64'(0));

        // abort mid-load after three beats, with a beat in the abort cycle
        beat(32'hB1, 1'b0);
        beat(32'hB2, 1'b0);
        abort = 1'b1;
        beat(32'hEE, 1'b1);
        abort = 1'b0;
        chk("abort_len", 64'(prog_len), 64'(0));
        chk("abort_idle", 64'({load_ready, busy}), 64'(2'b10));
        pulse_start();
        step();
        chk("abort_start_ign", 64'(cpu_set), 64'(0));

        // timeout with pc held
        beat(32'hC0, 1'b0);
        beat(32'hC1, 1'b1);
        pc = 8'd0;
        pulse_start();
        n = 0;
        while (!done && n < 1100) begin
            step();
            n++;
        end
        chk("to_cycles", 64'(n), 64'(1000));
        chk("to_timeout", 64'(timeout), 64'(1));
        chk("to_cnt", 64'(cycle_cnt), 64'(1000));
        chk("to_cpu_set", 64'(cpu_set), 64'(0));

        // end of program and limit on the same edge
        pulse_start();
        chk("tie_to_clr", 64'(timeout), 64'(0));
        repeat (999) step();
        chk("tie_busy", 64'(busy), 64'(1));
        pc = 8'd5;
        step();
        chk("tie_done", 64'(done), 64'(1));
        chk("tie_timeout", 64'(timeout), 64'(0));
        chk("tie_cnt", 64'(cycle_cnt), 64'(1000));

        // full buffer, implicit last
        pc = 8'd0;
        for (int i = 0; i < 256; i++)
            beat(32'h1000 + 32'(i), 1'b0);
        chk("full_len", 64'(prog_len), 64'(256));
        chk("full_ready", 64'({load_ready, busy}), 64'(0));
        beat(32'hDEAD, 1'b0);
        chk("full_no_257", 64'(prog_len), 64'(256));
        pulse_start();
        pc = 8'hFF;
        #1;
        chk("full_ins_ff", 64'(ins_out), 64'(32'h10FF));
        pc = 8'd3;
        #1;
        chk("full_ins_3", 64'(ins_out), 64'(32'h1003));

        // asynchronous reset mid-RUN
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_outs", 64'({cpu_set, done, busy}), 64'(0));
        chk("arst_ready", 64'(load_ready), 64'(1));
        chk("arst_ins", 64'(ins_out), 64'(NOP));
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_rst_idle", 64'({load_ready, busy, done}), 64'(3'b100));
        chk("post_rst_len", 64'(prog_len), 64'(0));
        chk("post_rst_cnt", 64'(cycle_cnt), 64'(0));
        pulse_start();
        step();
        chk("idle_start_ign", 64'(cpu_set), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
